pool_bin1: RTL and testbench

Streaming 2x2 binary max-pool stage directly downstream of the first binarized convolution/accumulate stage. It consumes the 18-channel, 24x24 binary feature map one image row at a time, with all channels in parallel. It emits a 12x12 pooled map for each channel, one pooled row per handshake. Binary max is a logical OR over each 2x2 window. Valid/ready handshakes on both sides decouple it from the conv stage and the next layer.

---
 rtl/pool_bin1_pkg.sv | 18 +
 rtl/pool_bin1_chan.sv | 18 +
 rtl/pool_bin1.sv | 92 +++++++++
 tb/tb_pool_bin1.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_bin1_pkg.sv
// Shared constants and types for the first binary 2x2 max-pool stage.
// Optional frame counter in pool_bin1 is enabled by POOL_BIN1_FRAMECNT_EN.
package pool_bin1_pkg;

  localparam int unsigned CH1 = 18;
  localparam int unsigned W1  = 24;
  localparam int unsigned H1  = 24;
  localparam int unsigned PW1 = W1 / 2;
  localparam int unsigned PH1 = H1 / 2;

  typedef enum logic {EVEN, ODD} pool_state_t;

  // Counter width that stays legal when only a single value is needed.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_bin1_chan.sv
// Combinational single-channel 2x2 binary max-pool: ORs each horizontal pixel
// pair across two consecutive rows. Bit 0 is the leftmost pixel.
module pool_bin1_chan #(
  parameter int unsigned W = 24
) (
  input  logic [0:W-1]   row_a,
  input  logic [0:W-1]   row_b,
  output logic [0:W/2-1] pooled
);

  always_comb begin
    pooled = '0;
    for (int p = 0; p < W / 2; p++) begin
      pooled[p] = row_a[2*p] | row_a[2*p+1] | row_b[2*p] | row_b[2*p+1];
    end
  end

endmodule

// File: rtl/pool_bin1.sv
// Streaming 2x2 binary max-pool over CH channels, one input row per handshake.
// Define POOL_BIN1_FRAMECNT_EN to add the frame_count output.
module pool_bin1
  import pool_bin1_pkg::*;
#(
  parameter int unsigned CH = CH1,
  parameter int unsigned W  = W1,
  parameter int unsigned H  = H1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:CH*W-1]   in_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:CH*W/2-1] out_row,
  output logic              out_last
`ifdef POOL_BIN1_FRAMECNT_EN
  ,
  output logic [7:0]        frame_count
`endif
);

  localparam int unsigned PW   = W / 2;
  localparam int unsigned PH   = H / 2;
  localparam int unsigned CntW = cnt_width(PH);

  pool_state_t      state;
  logic [CntW-1:0]  pair_cnt;
  logic [0:CH*W-1]  row_buf;
  logic [0:CH*PW-1] pooled;
  logic             in_hs;
  logic             out_hs;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    pool_bin1_chan #(
      .W(W)
    ) u_chan (
      .row_a (row_buf[c*W +: W]),
      .row_b (in_row[c*W +: W]),
      .pooled(pooled[c*PW +: PW])
    );
  end

  // The odd row may only land once the output register is free or draining.
  assign in_ready = (state == EVEN) | ~out_valid | out_ready;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EVEN;
      pair_cnt  <= '0;
      row_buf   <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (in_hs) begin
        case (state)
          EVEN: begin
            row_buf <= in_row;
            state   <= ODD;
          end
          ODD: begin
            out_row   <= pooled;
            out_valid <= 1'b1;
            out_last  <= (pair_cnt == CntW'(PH - 1));
            pair_cnt  <= (pair_cnt == CntW'(PH - 1)) ? '0 : pair_cnt + CntW'(1);
            state     <= EVEN;
          end
          default: state <= EVEN;
        endcase
      end
    end
  end

`ifdef POOL_BIN1_FRAMECNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (out_hs && out_last) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_bin1.sv
// Self-checking bench for pool_bin1 with a pixel-level reference model.
module tb_pool_bin1;
  import pool_bin1_pkg::*;

  localparam int CH = CH1;
  localparam int W  = W1;
  localparam int H  = H1;
  localparam int PW = PW1;
  localparam int PH = PH1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [0:CH*W-1]   in_row = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [0:CH*PW-1]  out_row;
  logic              out_last;
`ifdef POOL_BIN1_FRAMECNT_EN
  logic [7:0]        frame_count;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pool_bin1 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_last (out_last)
`ifdef POOL_BIN1_FRAMECNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  typedef struct packed {
    logic [0:CH*PW-1] row;
    logic             last;
  } res_t;

  res_t            got_q[$];
  res_t            exp_q[$];
  logic [0:CH*W-1] m_prev = '0;
  int              m_y = 0;
  bit              m_pend = 1'b0;

  // Pixel (c,y,x) of a row is bit c*W+x; a pooled pixel is the max of its 2x2 window.
  function automatic logic [0:CH*PW-1] pool2(input logic [0:CH*W-1] a,
                                             input logic [0:CH*W-1] b);
    logic [0:CH*PW-1] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      for (int p = 0; p < PW; p++) begin
        logic m;
        m = 1'b0;
        for (int dx = 0; dx < 2; dx++) begin
          if (a[c*W+2*p+dx]) m = 1'b1;
          if (b[c*W+2*p+dx]) m = 1'b1;
        end
        r[c*PW+p] = m;
      end
    end
    return r;
  endfunction

  function automatic logic [0:CH*W-1] rand_row();
    logic [0:CH*W-1] r;
    for (int i = 0; i < CH*W; i++) r[i] = 1'($urandom % 2);
    return r;
  endfunction

  // Observer: logs handshakes that will complete at the coming rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_q.push_back('{row: out_row, last: out_last});
        m_pend = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (m_y % 2 == 0) begin
          m_prev = in_row;
        end else begin
          exp_q.push_back('{row: pool2(m_prev, in_row), last: (m_y / 2 == PH - 1)});
          m_pend = 1'b1;
        end
        m_y = (m_y + 1) % H;
      end
    end
  end

  task automatic model_clear();
    got_q.delete();
    exp_q.delete();
    m_y    = 0;
    m_pend = 1'b0;
    m_prev = '0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_row(input logic [0:CH*W-1] r, output int waits);
    in_valid = 1'b1;
    in_row   = r;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_row_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_row    = '0;
    repeat (2) @(posedge clk);
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b required 0", out_last); end
    if (out_row !== '0) begin bad++; $display("FAIL reset_out_row: got %h required 0", out_row); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
`ifdef POOL_BIN1_FRAMECNT_EN
    total++;
    if (frame_count !== 8'd0) begin bad++; $display("FAIL reset_frame_count: got %0d required 0", frame_count); end
`endif
    rst_n = 1'b1;
    model_clear();
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_zero_frame();
    int w;
    out_ready = 1'b1;
    for (int y = 0; y < H; y++) begin
      send_row('0, w);
      total++;
      if (w !== 0) begin bad++; $display("FAIL zero_in_ready row %0d: stalled %0d cycles required 0", y, w); end
    end
    drain();
    total++;
    if (got_q.size() !== PH) begin bad++; $display("FAIL zero_count: got %0d required %0d", got_q.size(), PH); end
    for (int i = 0; i < got_q.size(); i++) begin
      total += 2;
      if (got_q[i].row !== '0) begin bad++; $display("FAIL zero_row %0d: got %h required 0", i, got_q[i].row); end
      if (got_q[i].last !== (i == PH - 1)) begin
        bad++; $display("FAIL zero_last %0d: got %b required %b", i, got_q[i].last, (i == PH - 1));
      end
    end
    model_clear();
  endtask

  task automatic test_single_pixel();
    int w;
    logic [0:CH*W-1] r;
    logic [0:CH*PW-1] oh;
    oh = '0;
    oh[5*PW+6] = 1'b1;
    out_ready = 1'b1;
    for (int y = 0; y < H; y++) begin
      r = '0;
      if (y == 7) r[5*W+13] = 1'b1;
      send_row(r, w);
    end
    drain();
    total++;
    if (got_q.size() !== PH) begin bad++; $display("FAIL pixel_count: got %0d required %0d", got_q.size(), PH); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i].row !== ((i == 3) ? oh : '0)) begin
        bad++; $display("FAIL pixel_row %0d: got %h required %h", i, got_q[i].row, (i == 3) ? oh : '0);
      end
    end
    model_clear();
  endtask

  task automatic test_backpressure();
    int w;
    logic [0:CH*W-1] r0, r1, r2, r3;
    logic [0:CH*PW-1] p01, p23;
    r0 = rand_row(); r1 = rand_row(); r2 = rand_row(); r3 = rand_row();
    p01 = pool2(r0, r1);
    p23 = pool2(r2, r3);
    out_ready = 1'b0;
    send_row(r0, w);
    send_row(r1, w);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_latency: out_valid got %b required 1", out_valid); end
    send_row(r2, w);
    total++;
    if (w !== 0) begin bad++; $display("FAIL bp_even_accept: stalled %0d cycles required 0", w); end
    in_valid = 1'b1;
    in_row   = r3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total += 2;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc %0d: got %b required 0", i, in_ready); end
      if (out_row !== p01 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold cyc %0d: got v=%b %h required v=1 %h", i, out_valid, out_row, p01);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 1", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total += 2;
    if (out_valid !== 1'b1 || out_row !== p23) begin
      bad++; $display("FAIL bp_replace: got v=%b %h required v=1 %h", out_valid, out_row, p23);
    end
    if (got_q.size() !== 1) begin
      bad++; $display("FAIL bp_first_taken: got %0d outputs required 1", got_q.size());
    end else if (got_q[0].row !== p01) begin
      bad++; $display("FAIL bp_first_taken: got %h required %h", got_q[0].row, p01);
    end
    for (int y = 4; y < H; y++) send_row(rand_row(), w);
    drain();
    total++;
    if (got_q.size() !== exp_q.size() || got_q.size() !== PH) begin
      bad++; $display("FAIL bp_count: got %0d model %0d required %0d", got_q.size(), exp_q.size(), PH);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_data %0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    model_clear();
  endtask

  task automatic test_midframe_reset();
    int w;
    out_ready = 1'b1;
    for (int y = 0; y < 8; y++) send_row(rand_row(), w);
    out_ready = 1'b0;
    send_row(rand_row(), w);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pending: out_valid got %b required 1", out_valid); end
    rst_n = 1'b0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
    if (out_row !== '0) begin bad++; $display("FAIL mid_out_row: got %h required 0", out_row); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    out_ready = 1'b1;
    for (int y = 0; y < H; y++) send_row(rand_row(), w);
    drain();
    total++;
    if (got_q.size() !== PH) begin bad++; $display("FAIL mid_count: got %0d required %0d", got_q.size(), PH); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total += 2;
      if (got_q[i].last !== (i == PH - 1)) begin
        bad++; $display("FAIL mid_last %0d: got %b required %b", i, got_q[i].last, (i == PH - 1));
      end
      if (got_q[i].row !== exp_q[i].row) begin
        bad++; $display("FAIL mid_data %0d: got %h required %h", i, got_q[i].row, exp_q[i].row);
      end
    end
    model_clear();
  endtask

  task automatic test_checkerboard();
    int w;
    logic [0:CH*W-1] r;
    out_ready = 1'b1;
    for (int y = 0; y < H; y++) begin
      for (int c = 0; c < CH; c++)
        for (int x = 0; x < W; x++) r[c*W+x] = 1'((x + y) & 1);
      send_row(r, w);
    end
    drain();
    total++;
    if (got_q.size() !== PH) begin bad++; $display("FAIL checker_count: got %0d required %0d", got_q.size(), PH); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++;
      if (got_q[i].row !== '1) begin bad++; $display("FAIL checker_row %0d: got %h required all ones", i, got_q[i].row); end
    end
    model_clear();
  endtask

  task automatic test_random();
    int n = 0;
    for (int cyc = 0; cyc < 2000 && n < 2*H; cyc++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_row    = rand_row();
      #1;
      total += 2;
      if (in_ready !== ((m_y % 2 == 0) || !m_pend || out_ready)) begin
        bad++; $display("FAIL rand_in_ready cyc %0d: got %b required %b", cyc, in_ready,
                        ((m_y % 2 == 0) || !m_pend || out_ready));
      end
      if (out_valid !== m_pend) begin
        bad++; $display("FAIL rand_out_valid cyc %0d: got %b required %b", cyc, out_valid, m_pend);
      end
      @(negedge clk);
      if (in_valid && in_ready) n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++;
    if (n < 2*H) begin bad++; $display("FAIL rand_timeout: accepted %0d rows required %0d", n, 2*H); end
    drain();
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data %0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    model_clear();
  endtask

`ifdef POOL_BIN1_FRAMECNT_EN
  task automatic test_framecnt();
    int w;
    test_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 257; f++)
      for (int y = 0; y < H; y++) send_row('0, w);
    drain();
    total++;
    if (frame_count !== 8'd1) begin bad++; $display("FAIL framecnt_wrap: got %0d required 1", frame_count); end
    model_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_frame();
    test_single_pixel();
    test_backpressure();
    test_midframe_reset();
    test_checkerboard();
    test_random();
`ifdef POOL_BIN1_FRAMECNT_EN
    test_framecnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
